// File: rtl/argon_branch_pkg.sv
// Shared definitions for the execute-stage branch resolver:
// condition codes, controller state encoding and the condition evaluation function.
package argon_branch_pkg;

    localparam logic [2:0] BEQ  = 3'h0;
    localparam logic [2:0] BNE  = 3'h1;
    localparam logic [2:0] BGE  = 3'h2;
    localparam logic [2:0] BGEU = 3'h3;
    localparam logic [2:0] BLT  = 3'h4;
    localparam logic [2:0] BLTU = 3'h5;

    typedef enum logic [1:0] {
        StIdle,
        StWaitFlags,
        StRedirect,
        StFlush
    } br_state_e;

    // Codes 6 and 7 are undefined and always resolve not-taken.
    function automatic logic cond_taken(input logic [2:0] br_type, input logic z,
                                        input logic s, input logic v, input logic c);
        logic taken;
        case (br_type)
            BEQ:     taken = z;
            BNE:     taken = ~z;
            BGE:     taken = (s == v);
            BGEU:    taken = c;
            BLT:     taken = (s != v);
            BLTU:    taken = ~c;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator; also flags the undefined codes 6/7.
module branch_cond_eval
    import argon_branch_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic       zero,
    input  logic       sign,
    input  logic       overflow,
    input  logic       carry,
    output logic       taken,
    output logic       bad_type
);

    assign taken    = cond_taken(br_type, zero, sign, overflow, carry);
    assign bad_type = br_type[2] & br_type[1];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch sequencer: accept, wait for flags, resolve, redirect fetch,
// hold flush, and keep saturating perf counters.
module branch_resolve_ctrl
    import argon_branch_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_br_valid,
    output logic              o_br_ready,
    input  logic [2:0]        i_br_type,
    input  logic [ADDR_W-1:0] i_br_target,
    input  logic              i_flags_valid,
    input  logic              i_flag_zero,
    input  logic              i_flag_sign,
    input  logic              i_flag_overflow,
    input  logic              i_flag_carry,
    output logic              o_stall,
    output logic              o_redirect_valid,
    input  logic              i_redirect_ready,
    output logic [ADDR_W-1:0] o_redirect_pc,
    output logic              o_flush,
    output logic              o_bad_type,
    output logic [CNT_W-1:0]  o_br_count,
    output logic [CNT_W-1:0]  o_taken_count
);

    localparam int unsigned FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES);

    br_state_e         state_q;
    logic [2:0]        type_q;
    logic [ADDR_W-1:0] target_q;
    logic [FW-1:0]     flush_cnt_q;
    logic [CNT_W-1:0]  br_cnt_q;
    logic [CNT_W-1:0]  taken_cnt_q;
    logic              bad_type_q;

    logic [2:0] eval_type;
    logic       taken;
    logic       eval_bad;
    logic       resolve;

    // Fast path evaluates the incoming type; otherwise the latched one.
    assign eval_type = (state_q == StIdle) ? i_br_type : type_q;
    assign resolve   = i_flags_valid &&
                       ((state_q == StIdle && i_br_valid) || state_q == StWaitFlags);

    branch_cond_eval u_cond_eval (
        .br_type  (eval_type),
        .zero     (i_flag_zero),
        .sign     (i_flag_sign),
        .overflow (i_flag_overflow),
        .carry    (i_flag_carry),
        .taken    (taken),
        .bad_type (eval_bad)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            type_q      <= '0;
            target_q    <= '0;
            flush_cnt_q <= '0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
            bad_type_q  <= 1'b0;
        end else begin
            bad_type_q <= resolve && eval_bad;
            if (resolve) begin
                if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
                if (taken && taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (i_br_valid) begin
                        type_q   <= i_br_type;
                        target_q <= i_br_target;
                        if (i_flags_valid) state_q <= taken ? StRedirect : StIdle;
                        else               state_q <= StWaitFlags;
                    end
                end
                StWaitFlags: begin
                    if (i_flags_valid) state_q <= taken ? StRedirect : StIdle;
                end
                StRedirect: begin
                    if (i_redirect_ready) begin
                        if (FLUSH_CYCLES > 0) begin
                            state_q     <= StFlush;
                            flush_cnt_q <= FLUSH_INIT;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StFlush: begin
                    if (flush_cnt_q <= FW'(1)) state_q <= StIdle;
                    else                       flush_cnt_q <= flush_cnt_q - 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_br_ready       = (state_q == StIdle);
    assign o_stall          = (state_q == StWaitFlags);
    assign o_redirect_valid = (state_q == StRedirect);
    assign o_flush          = (state_q == StRedirect) || (state_q == StFlush);
    assign o_redirect_pc    = target_q;
    assign o_bad_type       = bad_type_q;
    assign o_br_count       = br_cnt_q;
    assign o_taken_count    = taken_cnt_q;

endmodule
